// File: rtl/seg_mem_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mem_ctl
//  Purpose  : Segmented data-memory controller for the mixer DSP core.
//             It serves the register file, I/O channels and parameter memory,
//             and it also serves the instruction ROM.
//  Config   : MEMCTL_IO_DOUBLE_BUFFER_EN selects frame-synchronous I/O buffers.
//  Revision : 1.0  initial release
// ============================================================================
module seg_mem_ctl #(
   parameter int IAW = 9,
   parameter int IWW = 36,
   parameter int DAW = 10,
   parameter int DWW = 36,
   parameter int UAW = 7,
   parameter int NCH = 8,
   parameter int PW  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IAW-1:0]           addrI,
   output logic [IWW-1:0]           dataI,
   input  logic [DAW-1:0]           addrA,
   input  logic [DAW-1:0]           addrB,
   output logic [DWW-1:0]           dataA,
   output logic [DWW-1:0]           dataB,
   input  logic [DAW-1:0]           addrW,
   input  logic [DWW-1:0]           dataW,
   input  logic                     writeEn,
   output logic                     stall,
   input  logic                     sampleStrobe,
   input  logic [NCH-1:0][DWW-1:0]  inputs,
   output logic [NCH-1:0][DWW-1:0]  outputs,
   input  logic                     hostValid,
   input  logic [UAW-1:0]           hostAddr,
   input  logic [PW-1:0]            hostData,
   output logic                     hostReady,
   output logic                     segErr
);

   localparam int SW    = DAW - UAW;
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DEPTH = 1 << UAW;

   localparam logic [SW-1:0] SEG_RF  = SW'(0);
   localparam logic [SW-1:0] SEG_IO  = SW'(1);
   localparam logic [SW-1:0] SEG_PRM = SW'(2);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_SERVE_B = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [DWW-1:0] rf_mem  [DEPTH];
   logic [PW-1:0]  prm_mem [DEPTH];

   logic [SW-1:0]  seg_a, seg_b, seg_w;
   logic [UAW-1:0] da_a, da_b, da_w;
   logic [CHW-1:0] ch_a, ch_b, ch_w;

   assign {seg_a, da_a} = addrA;
   assign {seg_b, da_b} = addrB;
   assign {seg_w, da_w} = addrW;
   assign ch_a = da_a[CHW-1:0];
   assign ch_b = da_b[CHW-1:0];
   assign ch_w = da_w[CHW-1:0];

   logic [UAW-1:0] pend_q, pend_d;
   logic [DWW-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
   logic [IWW-1:0] data_i_q, data_i_d;
   logic           seg_err_q, seg_err_d;
   logic [NCH-1:0][DWW-1:0] outputs_q, outputs_d;
   logic [NCH-1:0][DWW-1:0] io_src;

   logic           conflict, wr_fire, host_fire;
   logic [UAW-1:0] prm_raddr;
   logic [PW-1:0]  prm_rd;
   logic [DWW-1:0] rd_a, rd_b;

   // The ROM image is a fixed address-derived pattern; swap in the program image here.
   function automatic logic [IWW-1:0] rom_word(input logic [IAW-1:0] a);
      return IWW'({~a, a});
   endfunction

   function automatic logic [DWW-1:0] pick_ch(input logic [NCH-1:0][DWW-1:0] v,
                                              input logic [CHW-1:0] ch);
      if (int'(ch) < NCH) return v[ch];
      return '0;
   endfunction

   // Stall depends only on the DSP read addresses and the FSM state.
   assign conflict  = (seg_a == SEG_PRM) && (seg_b == SEG_PRM) && (da_a != da_b);
   assign stall     = (state_q == ST_IDLE) && conflict;
   assign hostReady = !rst && (state_q == ST_IDLE) && (seg_a != SEG_PRM) && (seg_b != SEG_PRM);
   assign host_fire = hostValid && hostReady;
   assign wr_fire   = writeEn && !stall && !rst;

   // The parameter memory has a single read port, so the FSM selects its address.
   assign prm_raddr = (state_q == ST_SERVE_B) ? pend_q :
                      ((seg_a == SEG_PRM) ? da_a : da_b);
   assign prm_rd    = prm_mem[prm_raddr];

   always_comb begin
      rd_a = '0;
      case (seg_a)
         SEG_RF:  rd_a = rf_mem[da_a];
         SEG_IO:  rd_a = pick_ch(io_src, ch_a);
         SEG_PRM: rd_a = DWW'(prm_rd);
         default: rd_a = '0;
      endcase
   end

   always_comb begin
      rd_b = '0;
      case (seg_b)
         SEG_RF:  rd_b = rf_mem[da_b];
         SEG_IO:  rd_b = pick_ch(io_src, ch_b);
         SEG_PRM: rd_b = DWW'(prm_rd);
         default: rd_b = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      data_i_d  = rom_word(addrI);
      seg_err_d = seg_err_q
                  | (seg_a > SEG_PRM)
                  | (seg_b > SEG_PRM)
                  | (wr_fire && (seg_w >= SEG_PRM));
      case (state_q)
         ST_IDLE: begin
            data_a_d = rd_a;
            data_b_d = rd_b;
            if (conflict) begin
               data_b_d = data_b_q;
               pend_d   = da_b;
               state_d  = ST_SERVE_B;
            end
         end
         ST_SERVE_B: begin
            data_b_d = DWW'(prm_rd);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pend_q    <= '0;
         data_a_q  <= '0;
         data_b_q  <= '0;
         data_i_q  <= '0;
         seg_err_q <= 1'b0;
         outputs_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         data_i_q  <= data_i_d;
         seg_err_q <= seg_err_d;
         outputs_q <= outputs_d;
      end
   end

   // Storage arrays are not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_fire && (seg_w == SEG_RF)) rf_mem[da_w] <= dataW;
      if (host_fire) prm_mem[hostAddr] <= hostData;
   end

`ifdef MEMCTL_IO_DOUBLE_BUFFER_EN
   logic [NCH-1:0][DWW-1:0] in_shadow_q, in_shadow_d, out_stage_q, out_stage_d;

   // A write in a strobe cycle lands in the stage; the old stage goes out.
   always_comb begin
      in_shadow_d = in_shadow_q;
      out_stage_d = out_stage_q;
      outputs_d   = outputs_q;
      if (sampleStrobe) begin
         in_shadow_d = inputs;
         outputs_d   = out_stage_q;
      end
      if (wr_fire && (seg_w == SEG_IO) && (int'(ch_w) < NCH)) out_stage_d[ch_w] = dataW;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_shadow_q <= '0;
         out_stage_q <= '0;
      end else begin
         in_shadow_q <= in_shadow_d;
         out_stage_q <= out_stage_d;
      end
   end

   assign io_src = in_shadow_q;
`else
   logic unused_strobe;
   assign unused_strobe = sampleStrobe;

   always_comb begin
      outputs_d = outputs_q;
      if (wr_fire && (seg_w == SEG_IO) && (int'(ch_w) < NCH)) outputs_d[ch_w] = dataW;
   end

   assign io_src = inputs;
`endif

   assign dataA   = data_a_q;
   assign dataB   = data_b_q;
   assign dataI   = data_i_q;
   assign outputs = outputs_q;
   assign segErr  = seg_err_q;

endmodule
`default_nettype wire
